// File: rtl/wb_led_sequencer.sv
// wb_led_sequencer: a CPU-programmed engine that writes a blink pattern into
// the LED peripheral's DATA register. It then steps the peripheral's SHIFT
// register through 0..31, one step every PERIOD cycles. After setup the CPU
// does not touch the bus while the pattern plays.
//
// Handshake: a slave access is a cycle with i_wb_cyc & i_wb_stb high and
// o_wb_ack low. It is answered by a single-cycle o_wb_ack on the next edge,
// and read data is registered on that same edge. A master access raises
// o_m_cyc/o_m_stb with stable address and data. These are held until
// i_m_ack is sampled high, or until TIMEOUT cycles have elapsed.
module wb_led_sequencer #(
  parameter logic [31:0] LED_BASE = 32'h3000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  output logic [31:0] o_m_adr,
  output logic [31:0] o_m_dat,
  output logic [3:0]  o_m_sel,
  output logic        o_m_we,
  output logic        o_m_cyc,
  output logic        o_m_stb,
  input  logic        i_m_ack,
  output logic        o_busy,
  output logic        o_err
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_LOAD_WAIT = 3'd2,
    S_STEP      = 3'd3,
    S_STEP_WAIT = 3'd4,
    S_DELAY     = 3'd5
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic        ctrl_en, ctrl_oneshot, err_q;
  logic [31:0] period_q, pattern_q, load_dat_q, dly_q;
  logic [4:0]  shift_q;
  logic [7:0]  tmo_q;
  logic [31:0] rd_data;
  logic        slave_req, in_wait, tmo_hit, dly_done, last_step, fsm_stop;
  logic        unused_bits;

  // Byte selects and the untouched address bits play no part in decoding.
  assign unused_bits = ^{i_wb_sel, i_wb_adr[31:4], i_wb_adr[1:0]};

  assign slave_req = i_wb_cyc & i_wb_stb & ~o_wb_ack;
  assign in_wait   = (state_q == S_LOAD_WAIT) || (state_q == S_STEP_WAIT);
  // The tmo_q counter counts the cycles the strobe has been high. A
  // same-cycle ack pre-empts the abort.
  assign tmo_hit   = in_wait & ~i_m_ack & (tmo_q == TMO_LAST);
  assign dly_done  = (dly_q == 32'd0);
  assign last_step = (shift_q == 5'd31);
  assign o_busy    = (state_q != S_IDLE);
  assign o_err     = err_q;

  // State register; reset drops the master strobes immediately.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic. Losing EN abandons the run, but only between bus cycles.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (ctrl_en) state_d = S_LOAD;
      S_LOAD:      state_d = ctrl_en ? S_LOAD_WAIT : S_IDLE;
      S_LOAD_WAIT: begin
        if (i_m_ack)      state_d = ctrl_en ? S_STEP : S_IDLE;
        else if (tmo_hit) state_d = S_IDLE;
      end
      S_STEP:      state_d = ctrl_en ? S_STEP_WAIT : S_IDLE;
      S_STEP_WAIT: begin
        if (i_m_ack)      state_d = ctrl_en ? S_DELAY : S_IDLE;
        else if (tmo_hit) state_d = S_IDLE;
      end
      S_DELAY: begin
        if (!ctrl_en)          state_d = S_IDLE;
        else if (dly_done) begin
          if (!last_step)      state_d = S_STEP;
          else if (ctrl_oneshot) state_d = S_IDLE;
          else                 state_d = S_LOAD;
        end
      end
      default:     state_d = S_IDLE;
    endcase
  end

  // Output logic: master bus drive, plus the one-shot completion pulse.
  always_comb begin
    o_m_cyc  = 1'b0;
    o_m_stb  = 1'b0;
    o_m_we   = 1'b0;
    o_m_sel  = 4'h0;
    o_m_adr  = 32'h0;
    o_m_dat  = 32'h0;
    fsm_stop = 1'b0;
    unique case (state_q)
      S_LOAD: if (ctrl_en) begin
        o_m_cyc = 1'b1;
        o_m_adr = LED_BASE;
        o_m_dat = pattern_q;
      end
      S_LOAD_WAIT: begin
        o_m_cyc = 1'b1;
        o_m_adr = LED_BASE;
        o_m_dat = load_dat_q;
      end
      S_STEP: if (ctrl_en) begin
        o_m_cyc = 1'b1;
        o_m_adr = LED_BASE + 32'd4;
        o_m_dat = {27'b0, shift_q};
      end
      S_STEP_WAIT: begin
        o_m_cyc = 1'b1;
        o_m_adr = LED_BASE + 32'd4;
        o_m_dat = {27'b0, shift_q};
      end
      S_DELAY: fsm_stop = ctrl_en & dly_done & last_step & ctrl_oneshot;
      default: ;
    endcase
    o_m_stb = o_m_cyc;
    o_m_we  = o_m_cyc;
    o_m_sel = o_m_cyc ? 4'hF : 4'h0;
  end

  // Sequencer datapath: shift index, step delay, ack timeout, latched pattern.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      shift_q    <= 5'd0;
      dly_q      <= 32'd0;
      tmo_q      <= 8'd0;
      load_dat_q <= 32'd0;
    end else begin
      unique case (state_q)
        S_IDLE:      if (ctrl_en) shift_q <= 5'd0;
        S_LOAD: begin
          load_dat_q <= pattern_q;
          tmo_q      <= 8'd1;
        end
        S_LOAD_WAIT: if (!i_m_ack) tmo_q <= tmo_q + 8'd1;
        S_STEP:      tmo_q <= 8'd1;
        S_STEP_WAIT: begin
          if (!i_m_ack) tmo_q <= tmo_q + 8'd1;
          else          dly_q <= (period_q == 32'd0) ? 32'd0 : period_q - 32'd1;
        end
        S_DELAY: begin
          if (!dly_done)          dly_q <= dly_q - 32'd1;
          else if (ctrl_en) begin
            if (!last_step)       shift_q <= shift_q + 5'd1;
            else if (!ctrl_oneshot) shift_q <= 5'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // Register read mux; STATUS reflects live sequencer state.
  always_comb begin
    rd_data = 32'h0;
    unique case (i_wb_adr[3:2])
      2'd0: rd_data = {29'b0, err_q, ctrl_oneshot, ctrl_en};
      2'd1: rd_data = period_q;
      2'd2: rd_data = pattern_q;
      2'd3: rd_data = {13'b0, state_q, 3'b0, shift_q, 7'b0, o_busy};
      default: rd_data = 32'h0;
    endcase
  end

  // Slave port and control registers. The sequencer's own mode clear and
  // error set come last in this block, so they override a same-cycle write.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_wb_ack     <= 1'b0;
      o_wb_dat     <= 32'h0;
      ctrl_en      <= 1'b0;
      ctrl_oneshot <= 1'b0;
      err_q        <= 1'b0;
      period_q     <= 32'h0;
      pattern_q    <= 32'h0;
    end else begin
      o_wb_ack <= slave_req;
      if (slave_req) begin
        o_wb_dat <= rd_data;
        if (i_wb_we) begin
          unique case (i_wb_adr[3:2])
            2'd0: begin
              ctrl_en      <= i_wb_dat[0];
              ctrl_oneshot <= i_wb_dat[1];
              if (i_wb_dat[2]) err_q <= 1'b0;
            end
            2'd1: period_q  <= i_wb_dat;
            2'd2: pattern_q <= i_wb_dat;
            default: ;
          endcase
        end
      end
      if (fsm_stop || tmo_hit) begin
        ctrl_en      <= 1'b0;
        ctrl_oneshot <= 1'b0;
      end
      if (tmo_hit) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_led_sequencer.sv
// Bench for wb_led_sequencer. It contains an LED peripheral model with
// programmable ack latency, a master-bus monitor, and a reference list of
// expected LED writes and their spacing.
module tb_wb_led_sequencer;

  localparam logic [31:0] LED_BASE = 32'h3000_0000;
  localparam int          TIMEOUT  = 16;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic [31:0] i_wb_adr = '0, i_wb_dat = '0;
  logic [3:0]  i_wb_sel = '0;
  logic        i_wb_we = 1'b0, i_wb_cyc = 1'b0, i_wb_stb = 1'b0;
  logic [31:0] o_wb_dat, o_m_adr, o_m_dat;
  logic        o_wb_ack, o_m_we, o_m_cyc, o_m_stb, o_busy, o_err;
  logic [3:0]  o_m_sel;
  logic        i_m_ack = 1'b0;

  wb_led_sequencer #(.LED_BASE(LED_BASE), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_wb_adr(i_wb_adr), .i_wb_dat(i_wb_dat), .i_wb_sel(i_wb_sel),
    .i_wb_we(i_wb_we), .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
    .o_wb_dat(o_wb_dat), .o_wb_ack(o_wb_ack),
    .o_m_adr(o_m_adr), .o_m_dat(o_m_dat), .o_m_sel(o_m_sel), .o_m_we(o_m_we),
    .o_m_cyc(o_m_cyc), .o_m_stb(o_m_stb), .i_m_ack(i_m_ack),
    .o_busy(o_busy), .o_err(o_err)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int n_pass = 0, n_total = 0;
  logic [63:0] exp_q[$];
  int          exp_gap[$];
  logic [63:0] obs_q[$];
  int          obs_cyc[$];
  int          obs_len[$];
  int   cycle_no = 0, run_len = 0, ack_cnt = 0, ack_lat = 1;
  bit   no_ack = 1'b0;
  logic prev_cyc = 1'b0, prev_ack = 1'b0, mon_cyc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // LED peripheral model + monitor: acks in the (ack_lat+1)-th cycle after
  // the strobe first appears, and logs each write with its start cycle.
  always @(negedge i_clk) begin
    cycle_no++;
    mon_cyc = o_m_cyc && o_m_stb;
    if (prev_cyc && (prev_ack || !mon_cyc)) obs_len.push_back(run_len);
    if (mon_cyc && (!prev_cyc || prev_ack)) begin
      obs_q.push_back({o_m_adr, o_m_dat});
      obs_cyc.push_back(cycle_no);
      run_len = 0;
      ack_cnt = 0;
      check_eq("m_sel_we", {59'b0, o_m_sel, o_m_we}, {59'b0, 4'hF, 1'b1});
    end
    if (mon_cyc) begin
      run_len++;
      i_m_ack = !no_ack && (ack_cnt == ack_lat + 1);
      ack_cnt++;
    end else begin
      i_m_ack = 1'b0;
    end
    prev_ack = i_m_ack;
    prev_cyc = mon_cyc;
  end

  task automatic clear_obs();
    obs_q.delete();
    obs_cyc.delete();
    obs_len.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic wb_access(input logic [1:0] idx, input logic we, input logic [31:0] d,
                           output logic [31:0] rd);
    bit got;
    got = 1'b0;
    rd  = 32'h0;
    @(negedge i_clk);
    i_wb_adr = {28'h0, idx, 2'b00};
    i_wb_dat = d;
    i_wb_we  = we;
    i_wb_sel = 4'hF;
    i_wb_cyc = 1'b1;
    i_wb_stb = 1'b1;
    for (int k = 0; k < 4 && !got; k++) begin
      @(posedge i_clk);
      #1;
      if (o_wb_ack) begin
        got = 1'b1;
        rd  = o_wb_dat;
      end
    end
    check_eq("wb_ack", {63'b0, got}, 64'd1);
    i_wb_cyc = 1'b0;
    i_wb_stb = 1'b0;
    i_wb_we  = 1'b0;
  endtask

  task automatic wb_write(input logic [1:0] idx, input logic [31:0] d);
    logic [31:0] dummy;
    wb_access(idx, 1'b1, d, dummy);
  endtask

  task automatic wb_read(input logic [1:0] idx, output logic [31:0] d);
    wb_access(idx, 1'b0, 32'h0, d);
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string tag);
    int k;
    k = 0;
    while (o_busy !== lvl && k < budget) begin
      @(posedge i_clk);
      #1;
      k++;
    end
    check_eq(tag, {63'b0, o_busy}, {63'b0, lvl});
  endtask

  task automatic wait_obs(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (obs_q.size() < n && k < budget) begin
      @(posedge i_clk);
      #1;
      k++;
    end
    check_eq(tag, {63'b0, obs_q.size() >= n}, 64'd1);
  endtask

  // One-shot run against the reference: DATA write, then SHIFT 0..31.
  // Gaps: DATA->SHIFT0 = lat+2, SHIFT->SHIFT = max(period,1)+2+lat.
  task automatic run_oneshot(input logic [31:0] pat, input int per, input int lat);
    int eff;
    logic [31:0] rd;
    eff = (per == 0) ? 1 : per;
    ack_lat = lat;
    no_ack  = 1'b0;
    exp_q.delete();
    exp_gap.delete();
    exp_q.push_back({LED_BASE, pat});
    exp_gap.push_back(lat + 2);
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back({LED_BASE + 32'd4, 32'(i)});
      if (i < 31) exp_gap.push_back(eff + 2 + lat);
    end
    clear_obs();
    wb_write(2'd2, pat);
    wb_write(2'd1, 32'(per));
    wb_write(2'd0, 32'h3);
    wait_busy(1'b1, 10, "oneshot_start");
    wait_busy(1'b0, 33 * (eff + lat + 4) + 50, "oneshot_done");
    repeat (10) @(posedge i_clk);
    #1;
    check_eq("oneshot_count", 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check_eq("oneshot_write", obs_q[i], exp_q[i]);
    for (int i = 0; i < exp_gap.size() && i + 1 < obs_cyc.size(); i++)
      check_eq("oneshot_gap", 64'(obs_cyc[i+1] - obs_cyc[i]), 64'(exp_gap[i]));
    wb_read(2'd0, rd);
    check_eq("oneshot_ctrl", {32'h0, rd}, 64'h0);
    wb_read(2'd3, rd);
    check_eq("oneshot_status", {32'h0, rd}, 64'h0000_1F00);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] rd, pat0;
    int per, eff;

    repeat (3) @(posedge i_clk);
    #1;
    check_eq("rst_m_ctl", {57'b0, o_m_cyc, o_m_stb, o_m_we, o_m_sel}, 64'h0);
    check_eq("rst_m_bus", {o_m_adr, o_m_dat}, 64'h0);
    check_eq("rst_wb", {31'b0, o_wb_ack, o_wb_dat}, 64'h0);
    check_eq("rst_busy_err", {62'b0, o_busy, o_err}, 64'h0);
    @(negedge i_clk);
    i_reset_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      wb_read(2'(i), rd);
      check_eq("rst_reg", {32'h0, rd}, 64'h0);
    end
    wb_write(2'd3, 32'hFFFF_FFFF);
    wb_read(2'd3, rd);
    check_eq("status_ro", {32'h0, rd}, 64'h0);

    run_oneshot(32'hA5A5_0001, 4, 1);
    run_oneshot($urandom, 0, 1);
    run_oneshot($urandom, 1, 1);
    repeat (2) run_oneshot($urandom, $urandom_range(0, 6), $urandom_range(0, 3));

    // Continuous mode: a PATTERN change mid-run shows up at the wrap.
    ack_lat = 0;
    per  = $urandom_range(0, 2);
    eff  = (per == 0) ? 1 : per;
    pat0 = $urandom | 32'h8000_0000;
    clear_obs();
    wb_write(2'd2, pat0);
    wb_write(2'd1, 32'(per));
    wb_write(2'd0, 32'h1);
    wait_obs(2, 50, "cont_first");
    wb_write(2'd2, 32'h0000_FFFF);
    wait_obs(35, 33 * (eff + 4) + 50, "cont_wrap");
    wb_write(2'd0, 32'h0);
    wait_busy(1'b0, 100, "cont_stop");
    if (obs_q.size() >= 35) begin
      check_eq("cont_data0", obs_q[0], {LED_BASE, pat0});
      check_eq("cont_shift31", obs_q[32], {LED_BASE + 32'd4, 32'd31});
      check_eq("cont_rewrite", obs_q[33], {LED_BASE, 32'h0000_FFFF});
      check_eq("cont_shift0", obs_q[34], {LED_BASE + 32'd4, 32'd0});
      check_eq("cont_wrap_gap", 64'(obs_cyc[33] - obs_cyc[32]), 64'(eff + 2));
    end

    // Timeout: the peripheral never acks.
    no_ack = 1'b1;
    clear_obs();
    wb_write(2'd0, 32'h1);
    wait_busy(1'b1, 10, "tmo_start");
    wait_busy(1'b0, 60, "tmo_idle");
    repeat (3) @(posedge i_clk);
    #1;
    check_eq("tmo_count", 64'(obs_q.size()), 64'd1);
    if (obs_len.size() >= 1) check_eq("tmo_len", 64'(obs_len[0]), 64'(TIMEOUT));
    check_eq("tmo_err", {63'b0, o_err}, 64'd1);
    wb_read(2'd0, rd);
    check_eq("tmo_ctrl", {32'h0, rd}, 64'h4);
    wb_write(2'd0, 32'h4);
    wb_read(2'd0, rd);
    check_eq("err_clr_ctrl", {32'h0, rd}, 64'h0);
    check_eq("err_clr_pin", {63'b0, o_err}, 64'd0);

    // EN cleared during STEP_WAIT: the transfer finishes, then nothing more.
    no_ack  = 1'b0;
    ack_lat = 5;
    clear_obs();
    wb_write(2'd1, 32'd2);
    wb_write(2'd0, 32'h1);
    wait_obs(3, 100, "enclr_step1");
    wb_write(2'd0, 32'h0);
    wait_busy(1'b0, 50, "enclr_idle");
    repeat (20) @(posedge i_clk);
    #1;
    check_eq("enclr_count", 64'(obs_q.size()), 64'd3);
    if (obs_q.size() >= 3) check_eq("enclr_write", obs_q[2], {LED_BASE + 32'd4, 32'd1});
    if (obs_len.size() >= 3) check_eq("enclr_hold", 64'(obs_len[2]), 64'(ack_lat + 2));

    // Reset asserted mid-STEP_WAIT drops the strobes at once.
    clear_obs();
    wb_write(2'd0, 32'h1);
    wait_obs(3, 100, "rst_step1");
    @(negedge i_clk);
    #2;
    check_eq("rst_cyc_before", {63'b0, o_m_cyc}, 64'd1);
    i_reset_n = 1'b0;
    #1;
    check_eq("rst_cyc_after", {62'b0, o_m_cyc, o_m_stb}, 64'd0);
    check_eq("rst_busy_after", {63'b0, o_busy}, 64'd0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    wb_read(2'd0, rd);
    check_eq("rst_ctrl_after", {32'h0, rd}, 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_led_sequencer.md
Name: wb_led_sequencer

Overview:
- Wishbone-slave-configured controller that drives the LED peripheral through a Wishbone master port. It loads a 32-bit blink pattern into the LED DATA register, then steps the LED SHIFT register 0..31 at a programmable period, so the LED output plays the pattern bit by bit.
- It sits between the CPU bus (slave side) and the LED peripheral's Wishbone port (master side). It removes per-step CPU bus traffic.

Parameters:
- LED_BASE, 32'h3000_0000, byte address of the LED peripheral. DATA is at LED_BASE+0 and SHIFT is at LED_BASE+4.
- TIMEOUT, 16, cycles to wait for i_m_ack before aborting a master transaction. Range 2..255.

Ports:
- i_clk  in  1  system clock
- i_reset_n  in  1  asynchronous reset, active-low
- i_wb_adr  in  32  slave address; register index = i_wb_adr[3:2]
- i_wb_dat  in  32  slave write data
- i_wb_sel  in  4  byte select; ignored, all writes are full-word
- i_wb_we  in  1  slave write enable
- i_wb_cyc  in  1  slave cycle
- i_wb_stb  in  1  slave strobe
- o_wb_dat  out  32  slave read data
- o_wb_ack  out  1  slave acknowledge
- o_m_adr  out  32  master address
- o_m_dat  out  32  master write data
- o_m_sel  out  4  master byte select; always 4'hF while cyc is high
- o_m_we  out  1  master write enable; always 1 while cyc is high
- o_m_cyc  out  1  master cycle
- o_m_stb  out  1  master strobe
- i_m_ack  in  1  master acknowledge from the LED peripheral
- o_busy  out  1  high whenever the FSM is not IDLE
- o_err  out  1  sticky timeout flag

Behaviour:
- Reset (async assert, sync deassert by the reset tree):
  - All outputs 0, including o_wb_dat.
  - CTRL=0, PERIOD=0, PATTERN=0, shift counter=0, FSM=IDLE.
- Slave registers (index = i_wb_adr[3:2]):
  - 0 CTRL: bit0 EN, bit1 ONESHOT, bit2 ERR (write 1 to clear; reads the sticky flag).
  - 1 PERIOD: cycles per step. 0 is treated as 1.
  - 2 PATTERN: value loaded into LED DATA.
  - 3 STATUS: read-only. bit0 busy; bits[12:8] current shift index; bits[18:16] FSM state code.
- Slave handshake:
  - When i_wb_cyc & i_wb_stb & !o_wb_ack: o_wb_ack goes high for exactly one cycle on the next edge, and o_wb_dat is registered on that same edge.
  - A write takes effect on that edge.
  - Writes to STATUS are ignored.
- FSM states and encodings: IDLE=0, LOAD=1, LOAD_WAIT=2, STEP=3, STEP_WAIT=4, DELAY=5.
  - IDLE -> LOAD when EN=1. Clear the shift counter to 0.
  - LOAD: drive o_m_adr=LED_BASE, o_m_dat=PATTERN sampled at this cycle, cyc=stb=1. Go to LOAD_WAIT.
  - LOAD_WAIT: hold cyc/stb and the bus values until i_m_ack. On ack, drop cyc/stb on the next edge and go to STEP.
  - STEP: drive o_m_adr=LED_BASE+4, o_m_dat={27'b0, shift}, cyc=stb=1. Go to STEP_WAIT.
  - STEP_WAIT: on i_m_ack, drop cyc/stb, load the delay counter with max(PERIOD,1)-1, and go to DELAY.
  - DELAY: decrement the counter to 0, then leave.
    - If shift<31: increment shift and go to STEP.
    - If shift==31 and ONESHOT=1: clear EN and go to IDLE.
    - If shift==31 and ONESHOT=0: wrap shift to 0 and go to LOAD, so a PATTERN changed mid-run is picked up at the wrap.
  - Resulting step spacing: consecutive SHIFT-write start cycles are PERIOD + 2 + ack latency apart.
- EN cleared by software mid-run:
  - An in-flight master transaction (LOAD_WAIT or STEP_WAIT) completes normally; cyc is never dropped before ack or timeout.
  - The FSM then returns to IDLE instead of continuing.
  - From DELAY, LOAD or STEP the FSM goes to IDLE on the next edge. LOAD/STEP have not yet issued a bus cycle at that point.
- Timeout:
  - In either WAIT state, a counter that reaches TIMEOUT without ack drops cyc/stb, sets ERR/o_err, clears EN and goes to IDLE.
  - An ack arriving on the same cycle as the timeout wins; no error is flagged.
- Simultaneous write of ERR-clear and a new timeout: set wins.
- Reset asserted mid-transaction: cyc/stb fall immediately (async).

Test Plan:
- Reset, then read regs 0..3 -> all 0x0. o_m_cyc=0, o_busy=0.
- PATTERN=0xA5A5_0001, PERIOD=4, CTRL=0x3; LED model acks 1 cycle after stb -> expected master writes:
  - first, 0xA5A5_0001 to 0x3000_0000;
  - then SHIFT writes 0..31 to 0x3000_0004, start cycles 7 apart;
  - after shift 31: FSM returns to IDLE, CTRL reads 0x0, o_busy=0.
- Same setup with CTRL=0x1 -> after shift 31 a DATA rewrite occurs, then SHIFT=0. Change PATTERN to 0x0000_FFFF during the run -> the rewrite carries 0x0000_FFFF.
- PERIOD=0 vs PERIOD=1 -> identical step spacing of 3 + ack latency.
- LED model never acks, TIMEOUT=16 -> cyc falls exactly 16 cycles after stb; o_err=1, CTRL reads 0x4. Writing CTRL=0x4 clears the flag.
- Clear EN while in STEP_WAIT with ack delayed 5 cycles -> cyc is held until ack, then IDLE, with no further master cycles. Asserting i_reset_n=0 mid-STEP_WAIT drops cyc in the same cycle.
